// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer writer and the Sobel processor that reads the buffer.
package fb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StDone
    } fb_state_t;

    // Address width needed to hold a w x h frame linearly; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Raster position tracker: x, y and the linear base of the current row, so that the pixel address
// is row_base + x without a multiplier.
module frame_addr_counter #(
    parameter int unsigned Width     = 1280,
    parameter int unsigned Height    = 720,
    parameter int unsigned AddrWidth = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 step_i,
    input  logic                 line_advance_i,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 x_last_o,
    output logic                 y_last_o
);

    localparam int unsigned XW = $clog2(Width);
    localparam int unsigned YW = $clog2(Height);
    localparam logic [AddrWidth-1:0] RowStep = AddrWidth'(Width);

    logic [XW-1:0]        x_q, x_d, x_base;
    logic [YW-1:0]        y_q, y_d, y_base;
    logic [AddrWidth-1:0] row_q, row_d, row_base;

    // clear rebases to the origin first, so a step or advance in the same cycle starts from (0,0).
    always_comb begin
        x_base   = clear_i ? '0 : x_q;
        y_base   = clear_i ? '0 : y_q;
        row_base = clear_i ? '0 : row_q;
        x_d      = x_base;
        y_d      = y_base;
        row_d    = row_base;
        if (line_advance_i) begin
            x_d   = '0;
            y_d   = y_base + YW'(1);
            row_d = row_base + RowStep;
        end else if (step_i) begin
            x_d = x_base + XW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_q   <= '0;
            y_q   <= '0;
            row_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            row_q <= row_d;
        end
    end

    assign addr_o   = row_q + AddrWidth'(x_q);
    assign x_last_o = (x_q == XW'(Width - 1));
    assign y_last_o = (y_q == YW'(Height - 1));

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes a raster pixel stream into the frame buffer BRAM, checks SOF/EOL framing and holds the
// finished frame until the consumer releases it.
module frame_buffer_writer
    import fb_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 1280,
    parameter int unsigned IMG_HEIGHT = 720,
    parameter int unsigned PIXEL_BITS = 24,
    localparam int unsigned ADDR_WIDTH = addr_width(IMG_WIDTH, IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PIXEL_BITS-1:0] s_data,
    input  logic                  s_sof,
    input  logic                  s_eol,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [PIXEL_BITS-1:0] bram_wr_data,
    output logic                  frame_ready,
    input  logic                  frame_release,
    output logic                  line_err,
    output logic                  sof_err
);

    fb_state_t             state_q;
    logic                  s_ready_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [PIXEL_BITS-1:0] wr_data_q;
    logic                  frame_ready_q;
    logic                  line_err_q;
    logic                  sof_err_q;

    logic [ADDR_WIDTH-1:0] cnt_addr;
    logic                  cnt_x_last, cnt_y_last;
    logic                  cnt_clear, cnt_step, cnt_adv;
    logic                  accept, sof_beat, data_beat, beat, x_is_last, frame_end;

    // SOF beats restart at the origin, so they never see the counter's x_last.
    always_comb begin
        accept    = s_valid && s_ready_q;
        sof_beat  = accept && s_sof && (state_q != StDone);
        data_beat = accept && !s_sof && (state_q == StWrite);
        beat      = sof_beat || data_beat;
        x_is_last = data_beat && cnt_x_last;
        frame_end = x_is_last && cnt_y_last;
        cnt_clear = sof_beat || frame_end;
        cnt_adv   = beat && !frame_end && (s_eol || x_is_last);
        cnt_step  = beat && !frame_end && !(s_eol || x_is_last);
    end

    frame_addr_counter #(
        .Width     (IMG_WIDTH),
        .Height    (IMG_HEIGHT),
        .AddrWidth (ADDR_WIDTH)
    ) u_addr_counter (
        .clk_i          (clk),
        .rst_ni         (reset),
        .clear_i        (cnt_clear),
        .step_i         (cnt_step),
        .line_advance_i (cnt_adv),
        .addr_o         (cnt_addr),
        .x_last_o       (cnt_x_last),
        .y_last_o       (cnt_y_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            s_ready_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_ready_q <= 1'b0;
            line_err_q    <= 1'b0;
            sof_err_q     <= 1'b0;
        end else begin
            wr_en_q    <= beat;
            line_err_q <= beat && (s_eol != x_is_last);
            sof_err_q  <= sof_beat && (state_q == StWrite);
            if (beat) begin
                wr_addr_q <= sof_beat ? '0 : cnt_addr;
                wr_data_q <= s_data;
            end
            s_ready_q     <= 1'b1;
            frame_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sof_beat) state_q <= StWrite;
                end
                StWrite: begin
                    if (frame_end) begin
                        state_q   <= StDone;
                        s_ready_q <= 1'b0;
                    end
                end
                StDone: begin
                    // frame_ready lags DONE entry by a cycle so the last write commits first.
                    if (frame_release) begin
                        state_q <= StIdle;
                    end else begin
                        s_ready_q     <= 1'b0;
                        frame_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign frame_ready  = frame_ready_q;
    assign line_err     = line_err_q;
    assign sof_err      = sof_err_q;

endmodule
